// File: rtl/packets2magnitude_bytes.sv
// packets2magnitude_bytes: Avalon-ST packet sink that checks framing and
// emits saturated |re|+|im| bytes through a small show-ahead FIFO.
module packets2magnitude_bytes #(
    parameter int PACKET_LEN = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock_clk,
    input  logic        reset_reset,
    input  logic [16:0] asi_in0_data,
    input  logic        asi_in0_valid,
    output logic        asi_in0_ready,
    input  logic        asi_in0_startofpacket,
    input  logic        asi_in0_endofpacket,
    input  logic        asi_in0_empty,
    output logic [7:0]  aso_out0_data,
    output logic        aso_out0_valid,
    input  logic        aso_out0_ready,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count,
    output logic        err_pulse
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

    state_t        state_q;
    logic [12:0]   cnt_q;
    logic          run_q, pipe_valid_q, out_valid_q, err_pulse_q;
    logic [7:0]    pipe_q, out_q;
    logic [15:0]   pkt_q, err_q;
    logic [CW-1:0] mc_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [CW:0]   occ;
    logic          acc, sop, eop, last, err_d, push, load;
    logic [7:0]    abs_re, abs_im, byte_d;
    logic [8:0]    mag;
    logic          unused_ok;

    assign sop    = asi_in0_startofpacket;
    assign eop    = asi_in0_endofpacket;
    assign abs_re = asi_in0_data[16] ? 8'd0 - asi_in0_data[16:9] : asi_in0_data[16:9];
    assign abs_im = asi_in0_data[8]  ? 8'd0 - asi_in0_data[8:1]  : asi_in0_data[8:1];
    assign mag    = {1'b0, abs_re} + {1'b0, abs_im};
    assign byte_d = mag[8] ? 8'hFF : mag[7:0];

    // Occupancy counts the pipeline register, FIFO storage and output register.
    assign occ           = {1'b0, mc_q} + (CW+1)'(out_valid_q) + (CW+1)'(pipe_valid_q);
    assign asi_in0_ready = run_q && (occ < (CW+1)'(FIFO_DEPTH));
    assign acc           = asi_in0_valid && asi_in0_ready;
    assign last          = (cnt_q + 13'd1) == 13'(PACKET_LEN);
    assign err_d         = acc && ((state_q == IDLE && (!sop || eop)) ||
                                   (state_q == IN_PKT && (sop || (eop && !last))) ||
                                   (state_q == DROP && cnt_q == 13'd0));
    assign push          = pipe_valid_q;
    assign load          = (mc_q != '0) && (!out_valid_q || aso_out0_ready);

    assign aso_out0_data  = out_q;
    assign aso_out0_valid = out_valid_q;
    assign pkt_count      = pkt_q;
    assign err_count      = err_q;
    assign err_pulse      = err_pulse_q;
    assign unused_ok      = ^{asi_in0_data[0], asi_in0_empty};

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_q       <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            mc_q         <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            pkt_q        <= '0;
            err_q        <= '0;
            err_pulse_q  <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            pipe_valid_q <= acc && (state_q == IN_PKT || (state_q == IDLE && sop));
            if (acc) pipe_q <= byte_d;
            err_pulse_q  <= err_d;
            if (err_d && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (acc) begin
                case (state_q)
                    IDLE: if (sop && !eop) begin
                        state_q <= IN_PKT;
                        cnt_q   <= 13'd1;
                    end
                    IN_PKT: if (eop) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        if (!sop && last) pkt_q <= pkt_q + 16'd1;
                    end else if (sop) begin
                        cnt_q <= 13'd1;
                    end else if (last) begin
                        state_q <= DROP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                    // cnt_q==0 marks the first dropped beat, which owns the error.
                    default: if (eop) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= 13'd1;
                    end
                endcase
            end
            mc_q <= mc_q + CW'(push) - CW'(load);
            if (push) wr_q <= wr_q + 1'b1;
            if (load) begin
                rd_q  <= rd_q + 1'b1;
                out_q <= mem_q[rd_q];
            end
            out_valid_q <= load || (out_valid_q && !aso_out0_ready);
        end
    end

    always_ff @(posedge clock_clk) begin
        if (push) mem_q[wr_q] <= pipe_q;
    end
endmodule

// File: tb/tb_packets2magnitude_bytes.sv
// tb_packets2magnitude_bytes: directed framing, saturation, backpressure and
// reset vectors against hand-computed byte streams and counters.
module tb_packets2magnitude_bytes;
    logic        clk = 0, rst = 0;
    logic [16:0] din = '0;
    logic        vld = 0, sop_i = 0, eop_i = 0, ordy = 1;
    logic        rdy, ovalid, err_pulse;
    logic [7:0]  odata;
    logic [15:0] pkt_cnt, err_cnt;

    int total = 0, bad = 0, cyc = 0, n_acc = 0, nbytes = 0, pulses = 0;
    int last_acc = 0, lat_acc = 0, first_v = -1;
    logic [7:0] exp_q[$];
    logic [7:0] sre[4] = '{8'h80, 8'h80, 8'h7F, 8'hFF};
    logic [7:0] sim[4] = '{8'h80, 8'h00, 8'h7F, 8'h01};
    logic [7:0] sb[4]  = '{8'hFF, 8'h80, 8'hFE, 8'h02};

    packets2magnitude_bytes dut (
        .clock_clk(clk), .reset_reset(rst),
        .asi_in0_data(din), .asi_in0_valid(vld), .asi_in0_ready(rdy),
        .asi_in0_startofpacket(sop_i), .asi_in0_endofpacket(eop_i), .asi_in0_empty(1'b0),
        .aso_out0_data(odata), .aso_out0_valid(ovalid), .aso_out0_ready(ordy),
        .pkt_count(pkt_cnt), .err_count(err_cnt), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ovalid && ordy) begin
            nbytes++;
            if (exp_q.size() == 0) check("unexpected_byte", odata, -1);
            else check("byte", odata, exp_q.pop_front());
        end
        if (!rst && ovalid && first_v < 0) first_v = cyc;
        if (err_pulse) pulses++;
    end

    task automatic beat(input logic [7:0] re, input logic [7:0] im, input bit s, input bit e);
        int t = 0;
        din = {re, im, 1'b0}; sop_i = s; eop_i = e; vld = 1;
        while (!rdy && t < 1000) begin @(negedge clk); t++; end
        if (!rdy) check("beat_ready_timeout", rdy, 1);
        @(posedge clk);
        n_acc++;
        #1 last_acc = cyc;
        @(negedge clk);
        vld = 0; sop_i = 0; eop_i = 0;
    endtask

    task automatic pkt(input int n, input int eop_at, input int expn, input int mode);
        for (int i = 1; i <= n; i++) begin
            logic [7:0] re, im, b;
            re = 8'h05; im = 8'hFD; b = 8'h08;
            if (mode == 1 && i >= 2 && i <= 5) begin re = sre[i-2]; im = sim[i-2]; b = sb[i-2]; end
            if (mode == 2) begin re = 8'h00; im = 8'(i % 100); b = 8'(i % 100); end
            if (i <= expn) exp_q.push_back(b);
            beat(re, im, i == 1, i == eop_at);
            if (i == 1) lat_acc = last_acc;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || ovalid) && t < 5000) begin @(negedge clk); t++; end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int b0, p0, n0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy, 0);
        check("rst_valid", ovalid, 0);
        check("rst_data", odata, 0);
        check("rst_pkt", pkt_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_pulse", err_pulse, 0);
        rst = 0;
        @(posedge clk);
        #1 check("ready_after_rst", rdy, 1);
        @(negedge clk);

        b0 = nbytes;
        pkt(1024, 1024, 1024, 0);
        drain();
        check("latency", first_v - lat_acc, 2);
        check("good_bytes", nbytes - b0, 1024);
        check("good_pkt", pkt_cnt, 1);
        check("good_err", err_cnt, 0);

        pkt(1024, 1024, 1024, 1);
        drain();
        check("sat_pkt", pkt_cnt, 2);
        check("sat_err", err_cnt, 0);

        @(posedge clk);
        #1 ordy = 0;
        @(negedge clk);
        b0 = nbytes; n0 = n_acc;
        fork
            pkt(1024, 1024, 1024, 2);
            begin
                repeat (20) @(posedge clk);
                #1;
                check("bp_accepts", n_acc - n0, 4);
                check("bp_ready", rdy, 0);
                check("bp_hold_data", odata, 1);
                ordy = 1;
            end
        join
        drain();
        check("bp_bytes", nbytes - b0, 1024);
        check("bp_pkt", pkt_cnt, 3);

        b0 = nbytes; p0 = pulses;
        pkt(10, 10, 10, 0);
        drain();
        check("short_bytes", nbytes - b0, 10);
        check("short_err", err_cnt, 1);
        check("short_pulses", pulses - p0, 1);
        check("short_pkt", pkt_cnt, 3);
        pkt(1024, 1024, 1024, 0);
        drain();
        check("after_short_pkt", pkt_cnt, 4);

        b0 = nbytes; p0 = pulses;
        beat(8'h05, 8'hFD, 0, 0);
        repeat (5) @(negedge clk);
        check("nosop_bytes", nbytes - b0, 0);
        check("nosop_err", err_cnt, 2);
        check("nosop_pulses", pulses - p0, 1);

        b0 = nbytes;
        pkt(1029, 1029, 1024, 0);
        drain();
        check("long_bytes", nbytes - b0, 1024);
        check("long_err", err_cnt, 3);
        check("long_pkt", pkt_cnt, 4);
        pkt(1024, 1024, 1024, 0);
        drain();
        check("after_long_pkt", pkt_cnt, 5);
        check("after_long_err", err_cnt, 3);

        pkt(500, 0, 500, 0);
        rst = 1;
        exp_q.delete();
        #1;
        check("midrst_ready", rdy, 0);
        check("midrst_valid", ovalid, 0);
        check("midrst_data", odata, 0);
        check("midrst_pkt", pkt_cnt, 0);
        check("midrst_err", err_cnt, 0);
        check("midrst_pulse", err_pulse, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        b0 = nbytes;
        pkt(1024, 1024, 1024, 0);
        drain();
        check("postrst_bytes", nbytes - b0, 1024);
        check("postrst_pkt", pkt_cnt, 1);
        check("postrst_err", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
